// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port between WB (fixed priority) and the multi-cycle unit,
// buffering MC results in a small FIFO and tracking outstanding MC destinations in a busy scoreboard.
module regfile_write_arbiter #(
    parameter int QDEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wb_wen,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    input  logic        mc_valid,
    input  logic [4:0]  mc_addr,
    input  logic [31:0] mc_data,
    output logic        mc_ready,
    input  logic        issue_valid,
    input  logic [4:0]  issue_addr,
    input  logic [4:0]  rs_addr,
    input  logic [4:0]  rt_addr,
    input  logic [4:0]  rd_addr,
    output logic        stall,
    output logic        rf_wen,
    output logic [4:0]  rf_addr,
    output logic [31:0] rf_data,
    output logic        err
);
    // MC handshake: a beat transfers on any cycle where mc_valid && mc_ready; while mc_ready is
    // low the MC keeps mc_addr/mc_data stable. mc_ready never depends on mc_valid.
    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = $clog2(QDEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(QDEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(QDEPTH - 1);

    logic [4:0]       q_addr [QDEPTH];
    logic [31:0]      q_data [QDEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;
    logic [31:0]      busy;
    logic [31:0]      busy_next;
    logic             err_next;

    logic wb_sel;
    logic q_empty;
    logic accept;
    logic direct;
    logic pop;
    logic push;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        wb_sel   = wb_wen && (wb_addr != 5'd0);
        q_empty  = (count == '0);
        mc_ready = (count < DEPTH_C);
        accept   = mc_valid && mc_ready;
        pop      = !wb_sel && !q_empty;
        // Direct write only when nothing older is queued, which keeps MC commits in order.
        direct   = !wb_sel && q_empty && mc_valid && (mc_addr != 5'd0);
        push     = accept && (mc_addr != 5'd0) && !direct;
    end

    always_comb begin
        rf_wen  = 1'b0;
        rf_addr = 5'd0;
        rf_data = 32'd0;
        if (!reset) begin
            if (wb_sel) begin
                rf_wen  = 1'b1;
                rf_addr = wb_addr;
                rf_data = wb_data;
            end else if (pop) begin
                rf_wen  = 1'b1;
                rf_addr = q_addr[head];
                rf_data = q_data[head];
            end else if (direct) begin
                rf_wen  = 1'b1;
                rf_addr = mc_addr;
                rf_data = mc_data;
            end
        end
    end

    // Issue is applied after the commit clear so a same-cycle set of the same register wins.
    always_comb begin
        busy_next = busy;
        if (pop) begin
            busy_next[q_addr[head]] = 1'b0;
        end
        if (direct) begin
            busy_next[mc_addr] = 1'b0;
        end
        if (issue_valid && (issue_addr != 5'd0)) begin
            busy_next[issue_addr] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_comb begin
        err_next = err;
        if (accept && (mc_addr != 5'd0) && !busy[mc_addr]) begin
            err_next = 1'b1;
        end
        if (wb_sel && busy[wb_addr]) begin
            err_next = 1'b1;
        end
    end

    always_comb begin
        count_next = count;
        case ({push, pop})
            2'b10:   count_next = count + 1'b1;
            2'b01:   count_next = count - 1'b1;
            default: count_next = count;
        endcase
    end

    always_comb begin
        stall = busy[rs_addr] | busy[rt_addr] | busy[rd_addr];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            busy  <= 32'd0;
            err   <= 1'b0;
        end else begin
            if (pop) begin
                head <= ptr_inc(head);
            end
            if (push) begin
                tail <= ptr_inc(tail);
            end
            count <= count_next;
            busy  <= busy_next;
            err   <= err_next;
        end
    end

    // Queue payload needs no reset; entries are only read when count says they are valid.
    always_ff @(posedge clk) begin
        if (push) begin
            q_addr[tail] <= mc_addr;
            q_data[tail] <= mc_data;
        end
    end
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios with literal expectations plus a
// randomized phase, all checked every cycle against a queue/array model of the write port.
module tb_regfile_write_arbiter;
    localparam int QDEPTH = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wb_wen, mc_valid, issue_valid;
    logic [4:0]  wb_addr, mc_addr, issue_addr, rs_addr, rt_addr, rd_addr;
    logic [31:0] wb_data, mc_data;
    logic        mc_ready, stall, rf_wen, err;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;

    always #5 clk = ~clk;

    regfile_write_arbiter #(.QDEPTH(QDEPTH)) dut (
        .clk(clk), .reset(reset),
        .wb_wen(wb_wen), .wb_addr(wb_addr), .wb_data(wb_data),
        .mc_valid(mc_valid), .mc_addr(mc_addr), .mc_data(mc_data), .mc_ready(mc_ready),
        .issue_valid(issue_valid), .issue_addr(issue_addr),
        .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr), .stall(stall),
        .rf_wen(rf_wen), .rf_addr(rf_addr), .rf_data(rf_data), .err(err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: pending MC results in acceptance order, busy set, sticky error.
    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;
    ent_t        mq[$];
    logic [31:0] m_busy = 32'd0;
    logic        m_err = 1'b0;
    logic        mc_blocked = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic idle();
        wb_wen = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
        mc_valid = 1'b0; mc_addr = 5'd0; mc_data = 32'd0;
        issue_valid = 1'b0; issue_addr = 5'd0;
        rs_addr = 5'd0; rt_addr = 5'd0; rd_addr = 5'd0;
    endtask

    // Compare the DUT against the model for this cycle's inputs, then advance the model.
    task automatic compare_and_advance();
        logic        e_wen, e_ready, e_stall, pop, direct, accept;
        logic [4:0]  e_addr;
        logic [31:0] e_data, nb;
        e_ready = (mq.size() < QDEPTH);
        pop = 1'b0; direct = 1'b0;
        e_wen = 1'b0; e_addr = 5'd0; e_data = 32'd0;
        if (wb_wen && wb_addr != 5'd0) begin
            e_wen = 1'b1; e_addr = wb_addr; e_data = wb_data;
        end else if (mq.size() > 0) begin
            e_wen = 1'b1; e_addr = mq[0].a; e_data = mq[0].d; pop = 1'b1;
        end else if (mc_valid && mc_addr != 5'd0) begin
            e_wen = 1'b1; e_addr = mc_addr; e_data = mc_data; direct = 1'b1;
        end
        e_stall = m_busy[rs_addr] | m_busy[rt_addr] | m_busy[rd_addr];
        chk("rf_wen", 32'(rf_wen), 32'(e_wen));
        if (e_wen) begin
            chk("rf_addr", 32'(rf_addr), 32'(e_addr));
            chk("rf_data", rf_data, e_data);
        end
        chk("mc_ready", 32'(mc_ready), 32'(e_ready));
        chk("stall", 32'(stall), 32'(e_stall));
        chk("err", 32'(err), 32'(m_err));

        accept = mc_valid && e_ready;
        mc_blocked = mc_valid && !e_ready;
        if (accept && mc_addr != 5'd0 && !m_busy[mc_addr]) m_err = 1'b1;
        if (wb_wen && wb_addr != 5'd0 && m_busy[wb_addr]) m_err = 1'b1;
        nb = m_busy;
        if (pop) begin
            nb[mq[0].a] = 1'b0;
            void'(mq.pop_front());
        end
        if (direct) nb[mc_addr] = 1'b0;
        if (accept && mc_addr != 5'd0 && !direct) mq.push_back('{a: mc_addr, d: mc_data});
        if (issue_valid && issue_addr != 5'd0) nb[issue_addr] = 1'b1;
        m_busy = nb;
    endtask

    task automatic cycle();
        @(negedge clk);
        compare_and_advance();
        @(posedge clk);
        #1;
    endtask

    // Reset asserted mid-cycle with a live WB request to prove the port is gated.
    task automatic do_reset();
        idle();
        wb_wen = 1'b1; wb_addr = 5'd3; wb_data = 32'hDEAD_BEEF;
        reset = 1'b1;
        #1;
        chk("rst_rf_wen", 32'(rf_wen), 32'd0);
        chk("rst_mc_ready", 32'(mc_ready), 32'd1);
        mq.delete(); m_busy = 32'd0; m_err = 1'b0; mc_blocked = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        idle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        do_reset();

        // 1: direct MC write with WB idle
        issue_valid = 1'b1; issue_addr = 5'd5; cycle();
        idle(); rs_addr = 5'd5;
        mc_valid = 1'b1; mc_addr = 5'd5; mc_data = 32'hA5A5_A5A5;
        #1;
        chk("t1_wen", 32'(rf_wen), 32'd1);
        chk("t1_addr", 32'(rf_addr), 32'd5);
        chk("t1_data", rf_data, 32'hA5A5_A5A5);
        chk("t1_stall_same", 32'(stall), 32'd1);
        cycle();
        idle(); rs_addr = 5'd5; #1;
        chk("t1_stall_after", 32'(stall), 32'd0);
        cycle();

        // 2: MC result queued behind three WB writes
        issue_valid = 1'b1; issue_addr = 5'd8; cycle();
        for (int i = 0; i < 3; i++) begin
            idle(); rs_addr = 5'd8;
            wb_wen = 1'b1; wb_addr = 5'd3; wb_data = 32'(i);
            if (i == 0) begin
                mc_valid = 1'b1; mc_addr = 5'd8; mc_data = 32'h11;
            end
            #1;
            chk("t2_wb_addr", 32'(rf_addr), 32'd3);
            chk("t2_stall", 32'(stall), 32'd1);
            cycle();
        end
        idle(); rs_addr = 5'd8; #1;
        chk("t2_mc_addr", 32'(rf_addr), 32'd8);
        chk("t2_mc_data", rf_data, 32'h11);
        chk("t2_stall_commit", 32'(stall), 32'd1);
        cycle();
        #1;
        chk("t2_stall_clear", 32'(stall), 32'd0);
        cycle();

        // 3: queue fills, back-pressure, order preserved
        for (int r = 9; r <= 11; r++) begin
            idle(); issue_valid = 1'b1; issue_addr = 5'(r); cycle();
        end
        for (int r = 9; r <= 11; r++) begin
            idle();
            wb_wen = 1'b1; wb_addr = 5'd3; wb_data = 32'h3;
            mc_valid = 1'b1; mc_addr = 5'(r); mc_data = 32'h100 + 32'(r);
            #1;
            chk("t3_ready", 32'(mc_ready), (r == 11) ? 32'd0 : 32'd1);
            cycle();
        end
        idle(); mc_valid = 1'b1; mc_addr = 5'd11; mc_data = 32'h10B; #1;
        chk("t3_first", 32'(rf_addr), 32'd9);
        chk("t3_ready_full", 32'(mc_ready), 32'd0);
        cycle();
        #1;
        chk("t3_second", 32'(rf_addr), 32'd10);
        chk("t3_ready_free", 32'(mc_ready), 32'd1);
        cycle();
        idle(); #1;
        chk("t3_third", 32'(rf_addr), 32'd11);
        chk("t3_third_data", rf_data, 32'h10B);
        cycle();

        // 4: re-issue and commit of same register in one cycle
        issue_valid = 1'b1; issue_addr = 5'd4; cycle();
        idle(); issue_valid = 1'b1; issue_addr = 5'd4; rd_addr = 5'd4;
        mc_valid = 1'b1; mc_addr = 5'd4; mc_data = 32'h44;
        cycle();
        idle(); rd_addr = 5'd4; #1;
        chk("t4_stall_kept", 32'(stall), 32'd1);
        cycle();

        // 5: addr-0 beat dropped silently, unissued r7 raises sticky err
        do_reset();
        mc_valid = 1'b1; mc_addr = 5'd0; mc_data = 32'h77; #1;
        chk("t5_zero_wen", 32'(rf_wen), 32'd0);
        cycle();
        idle(); #1;
        chk("t5_zero_err", 32'(err), 32'd0);
        mc_valid = 1'b1; mc_addr = 5'd7; mc_data = 32'h7; cycle();
        idle(); #1;
        chk("t5_err", 32'(err), 32'd1);
        cycle(); cycle();
        chk("t5_err_sticky", 32'(err), 32'd1);

        // 6: reset with two queued entries
        do_reset();
        for (int r = 12; r <= 13; r++) begin
            idle(); issue_valid = 1'b1; issue_addr = 5'(r); cycle();
        end
        for (int r = 12; r <= 13; r++) begin
            idle(); wb_wen = 1'b1; wb_addr = 5'd3;
            mc_valid = 1'b1; mc_addr = 5'(r); mc_data = 32'(r); cycle();
        end
        chk("t6_full", 32'(mc_ready), 32'd0);
        do_reset();
        rs_addr = 5'd12; rt_addr = 5'd13; #1;
        chk("t6_ready", 32'(mc_ready), 32'd1);
        chk("t6_stall", 32'(stall), 32'd0);
        chk("t6_err", 32'(err), 32'd0);
        for (int i = 0; i < 3; i++) begin
            #1 chk("t6_no_write", 32'(rf_wen), 32'd0);
            cycle();
        end

        // Randomized traffic with periodic resets
        for (int c = 0; c < 1500; c++) begin
            logic [4:0] a;
            if (c % 300 == 299) do_reset();
            wb_wen = ($urandom_range(0, 9) < 4);
            wb_addr = 5'($urandom_range(0, 31));
            wb_data = $urandom;
            issue_valid = ($urandom_range(0, 9) < 3);
            issue_addr = 5'($urandom_range(0, 31));
            rs_addr = 5'($urandom_range(0, 31));
            rt_addr = 5'($urandom_range(0, 31));
            rd_addr = 5'($urandom_range(0, 31));
            if (!mc_blocked) begin
                mc_valid = ($urandom_range(0, 1) == 1);
                a = 5'($urandom_range(0, 31));
                for (int k = 0; k < 8; k++) begin
                    if (m_busy[a]) break;
                    a = 5'($urandom_range(0, 31));
                end
                mc_addr = a;
                mc_data = $urandom;
            end
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
